gerador_palavra: RTL and testbench

Transmit-side counterpart of the note-sequence word classifier. On a start request it plays the note sequence that the classifier recognises as the requested word type (adjective, comparative, adverb, or a deliberately invalid "nulo" word). Each note is driven on `nota` and qualified by an `ok` strobe with programmable setup, pulse and gap timing. It sits upstream of the classifier, or drives the classifier's pins in board-level loopback tests.

---
 rtl/palavra_pkg.sv | 77 +++++++
 rtl/temporizador_fase.sv | 29 ++
 rtl/gerador_palavra.sv | 145 ++++++++++++++
 tb/tb_gerador_palavra.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/palavra_pkg.sv
// Shared definitions for the note-sequence word generator: note codes, word
// types, FSM states and the helpers that map a word type onto its note sequence.
package palavra_pkg;

    localparam logic [3:0] nota_x1   = 4'b0000;
    localparam logic [3:0] nota_do   = 4'b0001;
    localparam logic [3:0] nota_re   = 4'b0010;
    localparam logic [3:0] nota_mi   = 4'b0011;
    localparam logic [3:0] nota_fa   = 4'b0100;
    localparam logic [3:0] nota_sol  = 4'b0101;
    localparam logic [3:0] nota_la   = 4'b0110;
    localparam logic [3:0] nota_si   = 4'b0111;
    localparam logic [3:0] nota_si_m = 4'b1111;

    localparam logic [1:0] tipo_nulo = 2'b00;
    localparam logic [1:0] tipo_adj  = 2'b01;
    localparam logic [1:0] tipo_comp = 2'b10;
    localparam logic [1:0] tipo_adv  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        GAP,
        DONE
    } estado_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Number of notes in the sequence, terminator included.
    function automatic logic [2:0] comprimento(input logic [1:0] tipo);
        logic [2:0] n;
        case (tipo)
            tipo_nulo: n = 3'd3;
            tipo_adj:  n = 3'd4;
            default:   n = 3'd5;
        endcase
        return n;
    endfunction

    // Note played at position idx; positions past the word body give the terminator.
    function automatic logic [3:0] nota_da_posicao(input logic [1:0] tipo,
                                                   input logic       alt,
                                                   input logic [2:0] idx,
                                                   input logic [3:0] n1,
                                                   input logic [3:0] n2);
        logic [3:0] r;
        r = nota_x1;
        case (idx)
            3'd0: r = n1;
            3'd1: r = n2;
            3'd2: begin
                case (tipo)
                    tipo_adj, tipo_comp: r = alt ? nota_si_m : nota_la;
                    tipo_adv:            r = nota_la;
                    default:             r = nota_x1;
                endcase
            end
            3'd3: begin
                case (tipo)
                    tipo_comp: r = alt ? nota_re : nota_do;
                    tipo_adv:  r = nota_si_m;
                    default:   r = nota_x1;
                endcase
            end
            default: r = nota_x1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/temporizador_fase.sv
// Loadable down-counter shared by the setup, strobe and gap phases; loading
// L-1 at phase entry makes the phase last exactly L cycles.
module temporizador_fase
    import palavra_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] valor,
    output logic         fim
);

    logic [W-1:0] contador;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contador <= '0;
        end else if (load) begin
            contador <= valor;
        end else if (contador != '0) begin
            contador <= contador - 1'b1;
        end
    end

    assign fim = (contador == '0);

endmodule

// File: rtl/gerador_palavra.sv
// Plays the note sequence of a requested word type on nota, qualified by an
// ok strobe with programmable setup, pulse and gap lengths.
module gerador_palavra
    import palavra_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] tipo,
    input  logic       alt,
    input  logic [3:0] nota1,
    input  logic [3:0] nota2,
    output logic [3:0] nota,
    output logic       ok,
    output logic       busy,
    output logic       done
);

    localparam int CMAX = max3(SETUP_CYC, PULSE_CYC, GAP_CYC);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(GAP_CYC - 1);

    estado_t estado, estado_prox;

    logic          armado;
    logic [1:0]    tipo_r;
    logic          alt_r;
    logic [3:0]    n1_r, n2_r;
    logic [2:0]    idx, idx_prox;
    logic [2:0]    ultimo;
    logic [3:0]    nota_prox;
    logic          carga;
    logic [CW-1:0] carga_valor;
    logic          fim_fase;

    assign ultimo = comprimento(tipo_r) - 3'd1;

    temporizador_fase #(
        .W(CW)
    ) u_temporizador (
        .clk   (clk),
        .reset (reset),
        .load  (carga),
        .valor (carga_valor),
        .fim   (fim_fase)
    );

    // The request is latched one cycle before the first note appears, which
    // keeps every output a plain register of the FSM's next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armado <= 1'b0;
            tipo_r <= tipo_nulo;
            alt_r  <= 1'b0;
            n1_r   <= nota_x1;
            n2_r   <= nota_x1;
        end else if (estado == IDLE && !armado && start) begin
            armado <= 1'b1;
            tipo_r <= tipo;
            alt_r  <= alt;
            n1_r   <= nota1;
            n2_r   <= nota2;
        end else begin
            armado <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
            idx    <= 3'd0;
            nota   <= nota_x1;
            ok     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            estado <= estado_prox;
            idx    <= idx_prox;
            nota   <= nota_prox;
            ok     <= (estado_prox == STROBE);
            busy   <= (estado_prox == SETUP) || (estado_prox == STROBE) || (estado_prox == GAP);
            done   <= (estado_prox == DONE);
        end
    end

    always_comb begin
        estado_prox = estado;
        idx_prox    = idx;
        nota_prox   = nota;
        carga       = 1'b0;
        carga_valor = '0;
        case (estado)
            IDLE: begin
                if (armado) begin
                    estado_prox = SETUP;
                    idx_prox    = 3'd0;
                    nota_prox   = nota_da_posicao(tipo_r, alt_r, 3'd0, n1_r, n2_r);
                    carga       = 1'b1;
                    carga_valor = LD_SETUP;
                end
            end
            SETUP: begin
                if (fim_fase) begin
                    estado_prox = STROBE;
                    carga       = 1'b1;
                    carga_valor = LD_PULSE;
                end
            end
            STROBE: begin
                if (fim_fase) begin
                    estado_prox = GAP;
                    carga       = 1'b1;
                    carga_valor = LD_GAP;
                end
            end
            GAP: begin
                if (fim_fase) begin
                    if (idx == ultimo) begin
                        estado_prox = DONE;
                    end else begin
                        estado_prox = SETUP;
                        idx_prox    = idx + 3'd1;
                        nota_prox   = nota_da_posicao(tipo_r, alt_r, idx + 3'd1, n1_r, n2_r);
                        carga       = 1'b1;
                        carga_valor = LD_SETUP;
                    end
                end
            end
            DONE: begin
                estado_prox = IDLE;
            end
            default: begin
                estado_prox = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gerador_palavra.sv
// Bench for gerador_palavra: two instances (default timing and 1/3/1 timing)
// compared every cycle against a timeline model, plus literal pins.
module tb_gerador_palavra;

    localparam int S0 = 2, P0 = 2, G0 = 2;
    localparam int S1 = 1, P1 = 3, G1 = 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] tipo;
    logic       alt;
    logic [3:0] nota1, nota2;

    logic [3:0] nota_d [2];
    logic       ok_d   [2];
    logic       busy_d [2];
    logic       done_d [2];

    int total = 0;
    int bad   = 0;

    int               cyc = 0;
    logic             act [2];
    int               e0  [2];
    int               len [2];
    logic [4:0][3:0]  sq  [2];

    gerador_palavra #(.SETUP_CYC(S0), .PULSE_CYC(P0), .GAP_CYC(G0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .tipo(tipo), .alt(alt),
        .nota1(nota1), .nota2(nota2),
        .nota(nota_d[0]), .ok(ok_d[0]), .busy(busy_d[0]), .done(done_d[0])
    );

    gerador_palavra #(.SETUP_CYC(S1), .PULSE_CYC(P1), .GAP_CYC(G1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .tipo(tipo), .alt(alt),
        .nota1(nota1), .nota2(nota2),
        .nota(nota_d[1]), .ok(ok_d[1]), .busy(busy_d[1]), .done(done_d[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int s_of(input int k); return (k == 0) ? S0 : S1; endfunction
    function automatic int p_of(input int k); return (k == 0) ? P0 : P1; endfunction
    function automatic int t_of(input int k);
        return (k == 0) ? (S0 + P0 + G0) : (S1 + P1 + G1);
    endfunction

    function automatic int seq_len(input logic [1:0] ty);
        case (ty)
            2'b00:   return 3;
            2'b01:   return 4;
            default: return 5;
        endcase
    endfunction

    // Word table: element [i] is the i-th note played.
    function automatic logic [4:0][3:0] seq_note(input logic [1:0] ty, input logic al,
                                                 input logic [3:0] a, input logic [3:0] b);
        logic [4:0][3:0] q;
        q = '0;
        q[0] = a;
        q[1] = b;
        case (ty)
            2'b01: q[2] = al ? 4'b1111 : 4'b0110;
            2'b10: begin
                q[2] = al ? 4'b1111 : 4'b0110;
                q[3] = al ? 4'b0010 : 4'b0001;
            end
            2'b11: begin
                q[2] = 4'b0110;
                q[3] = 4'b1111;
            end
            default: ;
        endcase
        return q;
    endfunction

    function automatic void expect_out(input int k, output logic [3:0] en,
                                       output logic eo, output logic eb, output logic ed);
        int t, tp, off;
        en = 4'b0000; eo = 1'b0; eb = 1'b0; ed = 1'b0;
        if (act[k]) begin
            tp = t_of(k);
            t  = cyc - e0[k] - 1;
            if (t >= 0 && t < len[k] * tp) begin
                en  = sq[k][t / tp];
                off = t % tp;
                eo  = (off >= s_of(k)) && (off < s_of(k) + p_of(k));
                eb  = 1'b1;
            end else if (t == len[k] * tp) begin
                ed = 1'b1;
            end
        end
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // Reference timeline: edge numbers of accepted starts per instance.
    initial begin
        act[0] = 1'b0; act[1] = 1'b0;
        e0[0] = 0; e0[1] = 0; len[0] = 0; len[1] = 0;
        sq[0] = '0; sq[1] = '0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                act[0] = 1'b0;
                act[1] = 1'b0;
            end else begin
                cyc++;
                for (int k = 0; k < 2; k++) begin
                    if (start && (!act[k] || cyc >= e0[k] + 3 + len[k] * t_of(k))) begin
                        act[k] = 1'b1;
                        e0[k]  = cyc;
                        sq[k]  = seq_note(tipo, alt, nota1, nota2);
                        len[k] = seq_len(tipo);
                    end
                end
            end
        end
    end

    initial begin
        logic [3:0] en;
        logic eo, eb, ed;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                expect_out(k, en, eo, eb, ed);
                check_output($sformatf("i%0d.nota", k), 32'(nota_d[k]), 32'(en));
                check_output($sformatf("i%0d.ok", k),   32'(ok_d[k]),   32'(eo));
                check_output($sformatf("i%0d.busy", k), 32'(busy_d[k]), 32'(eb));
                check_output($sformatf("i%0d.done", k), 32'(done_d[k]), 32'(ed));
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] ty, input logic al,
                                  input logic [3:0] a, input logic [3:0] b,
                                  input logic [4:0][3:0] exp_notes, input int exp_n,
                                  input int exp_done0, input int exp_done1,
                                  input logic perturb);
        logic [3:0] got[$];
        int d0 = -1;
        int d1 = -1;
        logic prev_ok = 1'b0;
        @(negedge clk);
        start = 1'b1; tipo = ty; alt = al; nota1 = a; nota2 = b;
        @(posedge clk);
        #2 start = 1'b0;
        for (int k = 1; k <= 100 && (d0 < 0 || d1 < 0); k++) begin
            @(posedge clk);
            #1;
            if (ok_d[0] && !prev_ok) got.push_back(nota_d[0]);
            prev_ok = ok_d[0];
            if (done_d[0] && d0 < 0) d0 = k;
            if (done_d[1] && d1 < 0) d1 = k;
            if (perturb) begin
                if (k == 5) begin tipo = 2'b11; nota1 = 4'b1010; end
                if (k == 7) start = 1'b1;
                if (k == 8) start = 1'b0;
            end
        end
        check_output("done0_offset", 32'(d0), 32'(exp_done0));
        check_output("done1_offset", 32'(d1), 32'(exp_done1));
        check_output("ok_pulses", 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            check_output($sformatf("note%0d", i),
                         (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx,
                         32'(exp_notes[i]));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tipo = 2'b00; alt = 1'b0;
        nota1 = 4'b0000; nota2 = 4'b0000;
        #3 reset = 1'b0;
        #1;
        check_output("rst.nota", 32'(nota_d[0]), 32'h0);
        check_output("rst.ok",   32'(ok_d[0]),   32'h0);
        check_output("rst.busy", 32'(busy_d[0]), 32'h0);
        check_output("rst.done", 32'(done_d[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        apply_stimulus(2'b01, 1'b0, 4'b0011, 4'b0101,
                       {4'h0, 4'h0, 4'h6, 4'h5, 4'h3}, 4, 25, 21, 1'b0);
        apply_stimulus(2'b10, 1'b1, 4'b0001, 4'b0010,
                       {4'h0, 4'h2, 4'hF, 4'h2, 4'h1}, 5, 31, 26, 1'b0);
        apply_stimulus(2'b11, 1'b0, 4'b0100, 4'b1000,
                       {4'h0, 4'hF, 4'h6, 4'h8, 4'h4}, 5, 31, 26, 1'b0);
        apply_stimulus(2'b00, 1'b1, 4'b0000, 4'b0111,
                       {4'h0, 4'h0, 4'h0, 4'h7, 4'h0}, 3, 19, 16, 1'b1);

        repeat (400) begin
            @(negedge clk);
            start = ($urandom_range(0, 5) == 0);
            tipo  = 2'($urandom);
            alt   = 1'($urandom);
            nota1 = 4'($urandom);
            nota2 = 4'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset while note 2 is being strobed on the default-timing instance.
        @(negedge clk);
        start = 1'b1; tipo = 2'b10; alt = 1'b0; nota1 = 4'b0101; nota2 = 4'b0011;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check_output("pre_rst.ok",   32'(ok_d[0]),   32'h1);
        check_output("pre_rst.nota", 32'(nota_d[0]), 32'h6);
        #1 reset = 1'b0;
        #1;
        check_output("async_rst.ok",   32'(ok_d[0]),   32'h0);
        check_output("async_rst.nota", 32'(nota_d[0]), 32'h0);
        check_output("async_rst.busy", 32'(busy_d[0]), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_output("post_rst.busy", 32'(busy_d[0]), 32'h0);

        apply_stimulus(2'b10, 1'b0, 4'b0101, 4'b0011,
                       {4'h0, 4'h1, 4'h6, 4'h3, 4'h5}, 5, 31, 26, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
